// File: rtl/axi4_lite_write_master_p.sv
// ---------------------------------------------------------------------------
// axi4_lite_write_master_p
//
// Single-beat AXI4-Lite write master. A start strobe in IDLE captures the
// address, data and byte strobes. The master then drives AW and W together
// and waits for the B response. The captured response is reported on
// resp_out/err, and done pulses for one cycle at the end of each transaction.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; the payload registers hold the last request
// ISSUE | AW and/or W valid outstanding until each channel handshakes
// RESP  | both channels accepted, B_READY high, waiting for B_VALID
// DONE  | one-cycle completion pulse, resp_out updated
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start                     request strobe, sampled only in IDLE
//   write_addr/data/strb      request payload
//   busy, done                transaction in progress / completion pulse
//   resp_out, err             last B_RESP, and error flag (resp_out[1])
//   AW_*, W_*, B_*            AXI4-Lite write channels
// ---------------------------------------------------------------------------
module axi4_lite_write_master_p #(
  parameter int          ADDR_W = 64,
  parameter int          DATA_W = 64,
  parameter logic [2:0]  PROT   = 3'b000,
  localparam int         STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              start,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [STRB_W-1:0] write_strb,

  output logic              busy,
  output logic              done,
  output logic [1:0]        resp_out,
  output logic              err,

  output logic [ADDR_W-1:0] AW_ADDR,
  output logic              AW_VALID,
  output logic [2:0]        AW_PROT,
  input  logic              AW_READY,

  output logic [DATA_W-1:0] W_DATA,
  output logic [STRB_W-1:0] W_STRB,
  output logic              W_VALID,
  input  logic              W_READY,

  input  logic [1:0]        B_RESP,
  input  logic              B_VALID,
  output logic              B_READY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [STRB_W-1:0]   strb_q;
  logic                aw_valid_q;
  logic                w_valid_q;
  logic                b_ready_q;
  logic                busy_q;
  logic                done_q;
  logic [1:0]          resp_q;

  // A channel's valid stays up until its own handshake. Once it drops, it
  // stays low for the rest of the transaction.
  logic aw_valid_d;
  logic w_valid_d;

  assign aw_valid_d = aw_valid_q & ~AW_READY;
  assign w_valid_d  = w_valid_q  & ~W_READY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_q     <= 2'b00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q     <= write_addr;
            data_q     <= write_data;
            strb_q     <= write_strb;
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          aw_valid_q <= aw_valid_d;
          w_valid_q  <= w_valid_d;
          // Both channels are finished when neither valid will remain
          // asserted. This covers either handshake order, or both in one cycle.
          if (!aw_valid_d && !w_valid_d) begin
            b_ready_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (B_VALID && b_ready_q) begin
            b_ready_q <= 1'b0;
            resp_q    <= B_RESP;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign AW_ADDR  = addr_q;
  assign AW_VALID = aw_valid_q;
  assign AW_PROT  = PROT;
  assign W_DATA   = data_q;
  assign W_STRB   = strb_q;
  assign W_VALID  = w_valid_q;
  assign B_READY  = b_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign resp_out = resp_q;
  assign err      = resp_q[1];

endmodule

// File: doc/axi4_lite_write_master_p.md
AXI4_LITE_WRITE_MASTER_P -- requirements
Module: axi4_lite_write_master_p

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, data width; legal values 32 or 64.
REQ-003 The block SHALL have parameter PROT, default 3'b000, constant driven on AW_PROT.
REQ-004 The block SHALL have derived localparam STRB_W = DATA_W/8.
REQ-005 The block SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1, request strobe; sampled only in IDLE.
REQ-008 The block SHALL have port write_addr, input, ADDR_W, target address.
REQ-009 The block SHALL have port write_data, input, DATA_W, write payload.
REQ-010 The block SHALL have port write_strb, input, STRB_W, byte lane enables.
REQ-011 The block SHALL have port busy, output, 1, transaction in progress.
REQ-012 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 The block SHALL have port resp_out, output, 2, captured B_RESP of the last transaction.
REQ-014 The block SHALL have port err, output, 1, asserted when resp_out[1]=1.
REQ-015 The block SHALL have AXI ports: AW_ADDR out ADDR_W; AW_VALID out 1; AW_PROT out 3; AW_READY in 1.
REQ-016 The block SHALL have AXI ports: W_DATA out DATA_W; W_STRB out STRB_W; W_VALID out 1; W_READY in 1.
REQ-017 The block SHALL have AXI ports: B_RESP in 2; B_VALID in 1; B_READY out 1.

Function
REQ-018 The block SHALL implement states IDLE, ISSUE, RESP, DONE.
REQ-019 In IDLE with start=1, the block SHALL register write_addr, write_data and write_strb, and go to ISSUE; AW_ADDR, W_DATA and W_STRB SHALL come from these registers and stay stable until the next accepted start.
REQ-020 The block SHALL assert AW_VALID and W_VALID together in the first ISSUE cycle (one cycle after start is sampled).
REQ-021 On each channel independently, a handshake is VALID&READY at a clock edge; after it, that VALID SHALL be 0 from the next cycle and SHALL NOT reassert in the same transaction.
REQ-022 AW and W handshakes SHALL be accepted in either order or in the same cycle.
REQ-023 Once a VALID is asserted, it SHALL stay high until its handshake completes; addr, data and strb SHALL NOT change during that time.
REQ-024 When both handshakes are complete, the block SHALL go to RESP with B_READY=1 from the next cycle; B_READY SHALL be 0 in every other state.
REQ-025 In RESP, on B_VALID&B_READY the block SHALL capture B_RESP into resp_out and go to DONE.
REQ-026 B_VALID arriving before RESP SHALL be ignored (B_READY low).
REQ-027 DONE SHALL last exactly one cycle with done=1, then the block SHALL return to IDLE.
REQ-028 busy SHALL be 1 in ISSUE, RESP and DONE, and 0 in IDLE.
REQ-029 start SHALL be ignored while busy=1; a start held high SHALL begin a new transaction in the first IDLE cycle after DONE.
REQ-030 resp_out and err SHALL hold their value until the next DONE.
REQ-031 Best-case latency SHALL be: start sampled at edge 0; AW/W accepted at edge 1; B accepted at edge 2; done=1 in the cycle after edge 2 (3 edges to done).
REQ-032 AW_PROT SHALL equal PROT at all times.

Reset
REQ-033 While rst=1, asynchronously and independent of clk, the block SHALL hold state=IDLE and AW_VALID=W_VALID=B_READY=busy=done=err=0, resp_out=2'b00, and address/data/strb registers=0.
REQ-034 Reset asserted mid-transaction SHALL abandon it with no done pulse; after reset release, the block SHALL accept a new start in the first cycle.

Verification
REQ-035 Verification SHALL cover: start with addr=0x8000_0010, data=0x1122334455667788, strb=0xFF, all READY=1, B_VALID=1, B_RESP=0 -> valids high 1 cycle, done on 3rd cycle, resp_out=00, err=0.
REQ-036 Verification SHALL cover: AW_READY delayed 4 cycles, W_READY immediate -> W_VALID drops after 1 cycle, AW_VALID held 5 cycles with stable AW_ADDR, B_READY rises only after AW handshake.
REQ-037 Verification SHALL cover: W_READY delayed 3 cycles, AW_READY immediate; write_data changed during the wait -> W_DATA keeps the registered value.
REQ-038 Verification SHALL cover: B_RESP=2'b10 (SLVERR) -> resp_out=10, err=1 held until next DONE; a following OKAY transaction clears err.
REQ-039 Verification SHALL cover: start pulsed while busy -> ignored; start held high through DONE -> second transaction begins in the next IDLE cycle.
REQ-040 Verification SHALL cover: rst asserted between clock edges while in RESP -> all outputs 0 immediately, no done; new start after release completes normally (DATA_W=32, strb=4'b0011 variant).
